// File: rtl/ram_4_bit_pkg.sv
// Shared defaults and word type for the ram_4_bit scratch RAM.
package ram_4_bit_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 32;

  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/ram_4_bit_array.sv
// Storage array for ram_4_bit: write port, whole-array synchronous clear, and an unregistered read tap.
module ram_4_bit_array
  import ram_4_bit_pkg::*;
#(
  parameter int WIDTH  = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Reset clears every word in one cycle so unwritten words read back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ram_4_bit.sv
// Single-port synchronous RAM with registered read data (1-cycle latency).
// Define RAM_4_BIT_PARITY_EN to store an even-parity bit per word and expose parity_err.
module ram_4_bit
  import ram_4_bit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [DATA_W-1:0] di,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
`ifdef RAM_4_BIT_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef RAM_4_BIT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int STORE_W = DATA_W + PAR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic               in_range;
  logic               we;
  logic [STORE_W-1:0] wdata;
  logic [STORE_W-1:0] rdata;
  logic [STORE_W-1:0] read_word;

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign we       = en & wr & in_range;

`ifdef RAM_4_BIT_PARITY_EN
  // Stored bit makes the whole word even, so XOR over data+parity flags corruption.
  assign wdata = {^di, di};
`else
  assign wdata = di;
`endif

  // Out-of-range reads return zero, which also gives a clean parity.
  assign read_word = in_range ? rdata : '0;

  ram_4_bit_array #(
    .WIDTH (STORE_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
`ifdef RAM_4_BIT_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (en && !wr) begin
      dout <= read_word[DATA_W-1:0];
`ifdef RAM_4_BIT_PARITY_EN
      parity_err <= ^read_word;
`endif
    end
  end

endmodule

// File: tb/tb_ram_4_bit.sv
// Self-checking bench for ram_4_bit against an array-based reference model.
// Parity checks compile only when RAM_4_BIT_PARITY_EN is defined.
module tb_ram_4_bit;
  import ram_4_bit_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       wr  = 1'b0;
  word_t      di  = '0;
  logic [4:0] addr = '0;
  word_t      dout;
`ifdef RAM_4_BIT_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  word_t model_mem [32];
  word_t model_dout = '0;

  ram_4_bit u_dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .wr  (wr),
    .di  (di),
    .addr(addr),
    .dout(dout)
`ifdef RAM_4_BIT_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Drive one access on the falling edge, update the model at the rising edge, settle 1ns.
  task automatic step(input logic r, input logic e, input logic w, input word_t d, input logic [4:0] a);
    @(negedge clk);
    rst = r; en = e; wr = w; di = d; addr = a;
    @(posedge clk);
    if (r) begin
      foreach (model_mem[i]) model_mem[i] = '0;
      model_dout = '0;
    end else if (e && w) begin
      model_mem[a] = d;
    end else if (e) begin
      model_dout = model_mem[a];
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 4'h0, 5'd0);
    checks++;
    if (dout !== 4'b0000) begin errors++; $display("[TB] FAIL reset_dout got %b want 0000", dout); end
    step(0, 1, 0, 4'h0, 5'd0);
    checks++;
    if (dout !== 4'b0000) begin errors++; $display("[TB] FAIL reset_read0 got %b want 0000", dout); end
    step(0, 1, 0, 4'h0, 5'd31);
    checks++;
    if (dout !== 4'b0000) begin errors++; $display("[TB] FAIL reset_read31 got %b want 0000", dout); end
  endtask

  task automatic test_write_read();
    step(0, 1, 1, 4'b0110, 5'd0);
    checks++;
    if (dout !== 4'b0000) begin errors++; $display("[TB] FAIL write_holds_dout got %b want 0000", dout); end
    step(0, 1, 0, 4'h0, 5'd0);
    checks++;
    if (dout !== 4'b0110) begin errors++; $display("[TB] FAIL readback0 got %b want 0110", dout); end
    step(0, 1, 0, 4'h0, 5'd1);
    checks++;
    if (dout !== 4'b0000) begin errors++; $display("[TB] FAIL unwritten1 got %b want 0000", dout); end
  endtask

  task automatic test_multi_word();
    step(0, 1, 1, 4'b1110, 5'd1);
    step(0, 1, 1, 4'b1010, 5'd31);
    step(0, 1, 1, 4'b0001, 5'd16);
    step(0, 1, 0, 4'h0, 5'd1);
    checks++;
    if (dout !== 4'b1110) begin errors++; $display("[TB] FAIL multi_read1 got %b want 1110", dout); end
    step(0, 1, 0, 4'h0, 5'd31);
    checks++;
    if (dout !== 4'b1010) begin errors++; $display("[TB] FAIL multi_read31 got %b want 1010", dout); end
    step(0, 1, 0, 4'h0, 5'd16);
    checks++;
    if (dout !== 4'b0001) begin errors++; $display("[TB] FAIL multi_read16 got %b want 0001", dout); end
  endtask

  task automatic test_enable_gating();
    step(0, 0, 1, 4'b1111, 5'd0);
    checks++;
    if (dout !== 4'b0001) begin errors++; $display("[TB] FAIL idle_hold_write got %b want 0001", dout); end
    step(0, 0, 0, 4'h0, 5'd1);
    checks++;
    if (dout !== 4'b0001) begin errors++; $display("[TB] FAIL idle_hold_read got %b want 0001", dout); end
    step(0, 1, 0, 4'h0, 5'd0);
    checks++;
    if (dout !== 4'b0110) begin errors++; $display("[TB] FAIL gated_mem0 got %b want 0110", dout); end
  endtask

  task automatic test_back_to_back();
    step(0, 1, 1, 4'b1001, 5'd7);
    step(0, 1, 0, 4'h0, 5'd7);
    checks++;
    if (dout !== 4'b1001) begin errors++; $display("[TB] FAIL raw_same_addr got %b want 1001", dout); end
  endtask

  task automatic test_mid_reset();
    step(0, 1, 1, 4'b0011, 5'd2);
    step(1, 1, 1, 4'b0101, 5'd2);
    checks++;
    if (dout !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_dout got %b want 0000", dout); end
    for (int a = 0; a < 3; a++) begin
      step(0, 1, 0, 4'h0, 5'(a));
      checks++;
      if (dout !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_read%0d got %b want 0000", a, dout); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           4'($urandom), 5'($urandom));
      checks++;
      if (dout !== model_dout) begin
        errors++;
        $display("[TB] FAIL random_%0d got %b want %b", n, dout, model_dout);
      end
`ifdef RAM_4_BIT_PARITY_EN
      checks++;
      if (parity_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random_parity_%0d got %b want 0", n, parity_err);
      end
`endif
    end
  endtask

`ifdef RAM_4_BIT_PARITY_EN
  task automatic test_parity();
    step(0, 1, 1, 4'b0111, 5'd5);
    u_dut.u_array.mem[5][4] = ~u_dut.u_array.mem[5][4];
    step(0, 1, 0, 4'h0, 5'd5);
    checks++;
    if (dout !== 4'b0111) begin errors++; $display("[TB] FAIL parity_dout got %b want 0111", dout); end
    checks++;
    if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL parity_err_set got %b want 1", parity_err); end
    step(0, 1, 1, 4'b1011, 5'd6);
    checks++;
    if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL parity_hold got %b want 1", parity_err); end
    step(0, 1, 0, 4'h0, 5'd6);
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL parity_clean got %b want 0", parity_err); end
  endtask
`endif

  initial begin
    foreach (model_mem[i]) model_mem[i] = '0;
    test_reset();
    test_write_read();
    test_multi_word();
    test_enable_gating();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef RAM_4_BIT_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
